// File: rtl/rv_data_mem.sv
// rv_data_mem: word-organised data memory for the MEM stage of the RV32 pipeline.
// Reads are combinational (zero latency); writes commit on the rising clock edge.
// The byte address is reduced to a word index by dropping addr[1:0], so every
// access is word-aligned. Indices at or beyond DEPTH read as zero and never write.
// Reset is asynchronous and active-high, and clears every word immediately.

module rv_data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    // Width of the full word index carried by the address.
    localparam int IDX_W = ADDR_W - 2;
    // Width needed to select one of the implemented words.
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Word count expressed at index width, for the range comparison.
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [SEL_W-1:0] sel;
    logic             idx_known;
    logic             in_range;
    logic             do_write;

    // The byte offset within a word plays no part in addressing.
    logic unused_byte_offset;
    assign unused_byte_offset = &{1'b0, addr[1:0]};

    assign idx = addr[ADDR_W-1:2];
    assign sel = idx[SEL_W-1:0];

    // An index containing X/Z never qualifies as a valid target; in hardware
    // this reduces to constant true, in simulation it keeps unknown addresses
    // from corrupting the array.
    assign idx_known = (^idx !== 1'bx);

    // Only indices inside the implemented range are accessed; there is no wrap.
    assign in_range = idx_known && (idx < DEPTH_IDX);

    // Writes are dropped for out-of-range or unknown indices.
    assign do_write = we && in_range;

    // Storage: asynchronous clear of every word, otherwise a full-word write on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[sel] <= wd;
        end
    end

    // Combinational read with no write-through bypass; zero while in reset or out of range.
    always_comb begin
        rd = '0;
        if (!reset && in_range) begin
            rd = mem[sel];
        end
    end

endmodule

// File: tb/tb_rv_data_mem.sv
// tb_rv_data_mem: directed and randomized checks of rv_data_mem against an
// array-based reference model. Drivers push expected read data into exp_q;
// a monitor on the falling edge pops and compares against rd.

module tb_rv_data_mem;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int unsigned DEPTH  = 64;

    logic              clk;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    rv_data_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .rd   (rd)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] model_mem [DEPTH];

    function automatic void model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        int unsigned word;
        word = a / 4;
        if (word < DEPTH) return model_mem[word];
        return '0;
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int unsigned word;
        word = a / 4;
        if (word < DEPTH) model_mem[word] = d;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    string             name_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic expect_rd(input logic [DATA_W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expected read per falling edge, compared against rd.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [DATA_W-1:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (rd === e) n_pass++;
            else $display("FAIL %s: addr=%h rd=%h expected=%h", nm, addr, rd, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic read_chk(input logic [ADDR_W-1:0] a, input string nm);
        @(posedge clk);
        #1;
        addr = a;
        we   = 1'b0;
        wd   = $urandom;
        expect_rd(model_read(a), nm);
    endtask

    // Drives a write for one edge; checks the old word before the edge and
    // the resulting word after it.
    task automatic write_chk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input string nm);
        @(posedge clk);
        #1;
        addr = a;
        wd   = d;
        we   = 1'b1;
        expect_rd(model_read(a), {nm, "_before"});
        @(posedge clk);
        if (!reset) model_write(a, d);
        #1;
        we = 1'b0;
        expect_rd(model_read(a), {nm, "_after"});
    endtask

    // Reset pulse placed entirely between clock edges.
    task automatic async_reset_chk(input logic [ADDR_W-1:0] a);
        @(posedge clk);
        #1;
        addr = a;
        we   = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
        expect_rd('0, "async_reset_rd");
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 99);
        if (sel < 70) return ADDR_W'($urandom_range(0, 4 * DEPTH - 1));
        if (sel < 85) return ADDR_W'(4 * DEPTH + $urandom_range(0, 255));
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        we    = 1'b1;
        wd    = 32'hFFFF_FFFF;
        addr  = '0;
        model_clear();

        // Reset held with a write attempted: everything reads zero.
        expect_rd('0, "reset_rd0");
        @(posedge clk); #1; addr = 32'd4;
        expect_rd('0, "reset_rd4");
        @(posedge clk); #1; addr = 32'd8;
        expect_rd('0, "reset_rd8");
        @(posedge clk); #1;
        reset = 1'b0;
        we    = 1'b0;
        read_chk(32'd0, "post_reset_rd0");
        read_chk(32'd4, "post_reset_rd4");
        read_chk(32'd8, "post_reset_rd8");

        // Basic write/read and neighbour isolation.
        write_chk(32'd0, 32'h1234_5678, "wr_word0");
        read_chk(32'd0, "hold_word0");
        write_chk(32'd4, 32'h8765_4321, "wr_word1");
        read_chk(32'd4, "rd_word1");
        read_chk(32'd0, "rd_word0_neighbour");

        // Alignment and bounds.
        read_chk(32'd3, "unaligned_rd3");
        write_chk(ADDR_W'(4 * DEPTH), 32'hDEAD_BEEF, "oob_wr");
        read_chk(32'd0, "oob_word0_unchanged");
        read_chk(ADDR_W'(4 * DEPTH - 1), "top_word_rd");

        // Read during write: old word before the edge, new word after.
        write_chk(32'd8, 32'hFEED_FACE, "rdw_word2");

        // Asynchronous reset between edges.
        async_reset_chk(32'd8);
        read_chk(32'd0, "after_async_rd0");
        read_chk(32'd4, "after_async_rd4");
        read_chk(32'd8, "after_async_rd8");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) write_chk(rand_addr(), $urandom, "rand_wr");
            else                           read_chk(rand_addr(), "rand_rd");
        end

        // Read back every implemented word.
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_chk(ADDR_W'(4 * i + $urandom_range(0, 3)), "sweep_rd");
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: time=%0t limit=1000000", $time);
        $fatal(1, "timeout");
    end

endmodule
